// File: rtl/operand_fetch_pkg.sv
// Shared constants and helpers for the ID-stage operand fetch block.
// Holds the GPR geometry, the names of the operand sources, and the
// priority rule that picks a source for one read port.
package operand_fetch_pkg;

   localparam int DATA_W     = 32;
   localparam int REG_ADDR_W = 5;
   localparam int REG_COUNT  = 32;
   localparam int ZERO_REG   = 0;

   // Where a resolved operand comes from, in priority order.
   typedef enum logic [2:0] {
      SRC_OFF  = 3'd0,
      SRC_ZERO = 3'd1,
      SRC_EX   = 3'd2,
      SRC_MEM  = 3'd3,
      SRC_WB   = 3'd4,
      SRC_GPR  = 3'd5
   } src_sel_t;

   // First match wins. A disabled port or r0 never looks at the forwarding
   // network. EX is the youngest producer, so it beats MEM, which beats WB.
   function automatic src_sel_t resolve_sel(
      input logic read_en,
      input logic addr_is_zero,
      input logic ex_hit,
      input logic mem_hit,
      input logic wb_hit
   );
      src_sel_t sel;
      if (!read_en)
         sel = SRC_OFF;
      else if (addr_is_zero)
         sel = SRC_ZERO;
      else if (ex_hit)
         sel = SRC_EX;
      else if (mem_hit)
         sel = SRC_MEM;
      else if (wb_hit)
         sel = SRC_WB;
      else
         sel = SRC_GPR;
      return sel;
   endfunction

endpackage

// File: rtl/operand_fetch_reg_file.sv
// General-purpose register file: one synchronous write port, two
// asynchronous read ports. All GPR state and the r0 write guard live here.
import operand_fetch_pkg::*;

module operand_fetch_reg_file #(
   parameter int DATA_WIDTH = DATA_W,
   parameter int ADDR_WIDTH = REG_ADDR_W
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  write_en,
   input  logic [ADDR_WIDTH-1:0] write_addr,
   input  logic [DATA_WIDTH-1:0] write_data,
   input  logic [ADDR_WIDTH-1:0] read_addr_1,
   output logic [DATA_WIDTH-1:0] read_data_1,
   input  logic [ADDR_WIDTH-1:0] read_addr_2,
   output logic [DATA_WIDTH-1:0] read_data_2
);

   localparam int DEPTH = 2 ** ADDR_WIDTH;

   logic [DATA_WIDTH-1:0] regs [DEPTH];
   logic                  write_ok;

   // r0 is hard-wired; a write aimed at it is silently discarded.
   assign write_ok = write_en && (write_addr != ADDR_WIDTH'(ZERO_REG));

   // Reset wipes every register and wins over a write in the same cycle.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < DEPTH; i++) begin
            regs[i] <= '0;
         end
      end else if (write_ok) begin
         regs[write_addr] <= write_data;
      end
   end

   // Asynchronous reads; r0 reads as zero even before the first reset.
   always_comb begin
      read_data_1 = regs[read_addr_1];
      if (read_addr_1 == ADDR_WIDTH'(ZERO_REG)) begin
         read_data_1 = '0;
      end
   end

   // Second read port mirrors the first.
   always_comb begin
      read_data_2 = regs[read_addr_2];
      if (read_addr_2 == ADDR_WIDTH'(ZERO_REG)) begin
         read_data_2 = '0;
      end
   end

endmodule

// File: rtl/operand_fetch.sv
// ID-stage operand fetch. Reads rs/rt from the GPR file, resolves them
// through EX/MEM/WB forwarding, and flags a load-use hazard when the
// instruction in EX is a load whose result is needed right now.
import operand_fetch_pkg::*;

module operand_fetch #(
   parameter int DATA_WIDTH = DATA_W,
   parameter int ADDR_WIDTH = REG_ADDR_W
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  read_en_1,
   input  logic [ADDR_WIDTH-1:0] read_addr_1,
   input  logic                  read_en_2,
   input  logic [ADDR_WIDTH-1:0] read_addr_2,
   input  logic                  ex_write_en,
   input  logic [ADDR_WIDTH-1:0] ex_write_addr,
   input  logic [DATA_WIDTH-1:0] ex_write_data,
   input  logic                  ex_is_load,
   input  logic                  mem_write_en,
   input  logic [ADDR_WIDTH-1:0] mem_write_addr,
   input  logic [DATA_WIDTH-1:0] mem_write_data,
   input  logic                  wb_write_en,
   input  logic [ADDR_WIDTH-1:0] wb_write_addr,
   input  logic [DATA_WIDTH-1:0] wb_write_data,
   output logic [DATA_WIDTH-1:0] read_data_1,
   output logic [DATA_WIDTH-1:0] read_data_2,
   output logic                  stall_req
);

   logic [DATA_WIDTH-1:0] gpr_data_1;
   logic [DATA_WIDTH-1:0] gpr_data_2;

   logic     ex_hit_1, mem_hit_1, wb_hit_1;
   logic     ex_hit_2, mem_hit_2, wb_hit_2;
   logic     zero_1, zero_2;
   logic     load_use_1, load_use_2;
   src_sel_t sel_1, sel_2;

   logic [DATA_WIDTH-1:0] fwd_data_1;
   logic [DATA_WIDTH-1:0] fwd_data_2;

   operand_fetch_reg_file #(
      .DATA_WIDTH (DATA_WIDTH),
      .ADDR_WIDTH (ADDR_WIDTH)
   ) u_reg_file (
      .clk         (clk),
      .rst         (rst),
      .write_en    (wb_write_en),
      .write_addr  (wb_write_addr),
      .write_data  (wb_write_data),
      .read_addr_1 (read_addr_1),
      .read_data_1 (gpr_data_1),
      .read_addr_2 (read_addr_2),
      .read_data_2 (gpr_data_2)
   );

   // Turn a source selection into data for one port.
   function automatic logic [DATA_WIDTH-1:0] pick(
      input src_sel_t              sel,
      input logic [DATA_WIDTH-1:0] ex_d,
      input logic [DATA_WIDTH-1:0] mem_d,
      input logic [DATA_WIDTH-1:0] wb_d,
      input logic [DATA_WIDTH-1:0] gpr_d
   );
      logic [DATA_WIDTH-1:0] d;
      case (sel)
         SRC_EX:  d = ex_d;
         SRC_MEM: d = mem_d;
         SRC_WB:  d = wb_d;
         SRC_GPR: d = gpr_d;
         default: d = '0;
      endcase
      return d;
   endfunction

   // Address comparisons of each read port against every in-flight writer.
   always_comb begin
      zero_1    = (read_addr_1 == ADDR_WIDTH'(ZERO_REG));
      zero_2    = (read_addr_2 == ADDR_WIDTH'(ZERO_REG));
      ex_hit_1  = ex_write_en  && (ex_write_addr  == read_addr_1);
      ex_hit_2  = ex_write_en  && (ex_write_addr  == read_addr_2);
      mem_hit_1 = mem_write_en && (mem_write_addr == read_addr_1);
      mem_hit_2 = mem_write_en && (mem_write_addr == read_addr_2);
      wb_hit_1  = wb_write_en  && (wb_write_addr  == read_addr_1);
      wb_hit_2  = wb_write_en  && (wb_write_addr  == read_addr_2);
   end

   // Priority resolution and data mux for both ports, independently.
   always_comb begin
      sel_1      = resolve_sel(read_en_1, zero_1, ex_hit_1, mem_hit_1, wb_hit_1);
      sel_2      = resolve_sel(read_en_2, zero_2, ex_hit_2, mem_hit_2, wb_hit_2);
      fwd_data_1 = pick(sel_1, ex_write_data, mem_write_data, wb_write_data, gpr_data_1);
      fwd_data_2 = pick(sel_2, ex_write_data, mem_write_data, wb_write_data, gpr_data_2);
   end

   // A load in EX has no data yet; any live consumer of its target must wait.
   always_comb begin
      load_use_1 = read_en_1 && !zero_1 && ex_hit_1 && ex_is_load;
      load_use_2 = read_en_2 && !zero_2 && ex_hit_2 && ex_is_load;
   end

   // Reset blanks both operands and suppresses any stall.
   always_comb begin
      read_data_1 = rst ? '0 : fwd_data_1;
      read_data_2 = rst ? '0 : fwd_data_2;
      stall_req   = !rst && (load_use_1 || load_use_2);
   end

endmodule

// File: tb/tb_operand_fetch.sv
// Directed bench for operand_fetch. Each step drives inputs after the
// falling edge, pushes the expected outputs onto a scoreboard, then pops
// and compares them before the next rising edge.
module tb_operand_fetch;

   logic        clk = 1'b0;
   logic        rst;
   logic        read_en_1, read_en_2;
   logic [4:0]  read_addr_1, read_addr_2;
   logic        ex_write_en, ex_is_load;
   logic [4:0]  ex_write_addr;
   logic [31:0] ex_write_data;
   logic        mem_write_en;
   logic [4:0]  mem_write_addr;
   logic [31:0] mem_write_data;
   logic        wb_write_en;
   logic [4:0]  wb_write_addr;
   logic [31:0] wb_write_data;
   logic [31:0] read_data_1, read_data_2;
   logic        stall_req;

   typedef struct {
      string       tag;
      int          port;
      logic [31:0] value;
   } exp_t;

   exp_t sb[$];
   int   total = 0;
   int   bad   = 0;

   operand_fetch dut (
      .clk            (clk),
      .rst            (rst),
      .read_en_1      (read_en_1),
      .read_addr_1    (read_addr_1),
      .read_en_2      (read_en_2),
      .read_addr_2    (read_addr_2),
      .ex_write_en    (ex_write_en),
      .ex_write_addr  (ex_write_addr),
      .ex_write_data  (ex_write_data),
      .ex_is_load     (ex_is_load),
      .mem_write_en   (mem_write_en),
      .mem_write_addr (mem_write_addr),
      .mem_write_data (mem_write_data),
      .wb_write_en    (wb_write_en),
      .wb_write_addr  (wb_write_addr),
      .wb_write_data  (wb_write_data),
      .read_data_1    (read_data_1),
      .read_data_2    (read_data_2),
      .stall_req      (stall_req)
   );

   // Free-running core clock, 10 ns period.
   always #5 clk = ~clk;

   // Quiet every input except reset.
   task automatic idleInputs();
      read_en_1 = 1'b0; read_addr_1 = '0;
      read_en_2 = 1'b0; read_addr_2 = '0;
      ex_write_en = 1'b0; ex_write_addr = '0; ex_write_data = '0; ex_is_load = 1'b0;
      mem_write_en = 1'b0; mem_write_addr = '0; mem_write_data = '0;
      wb_write_en = 1'b0; wb_write_addr = '0; wb_write_data = '0;
   endtask

   // Push the expected port-1, port-2 and stall values for the current drive.
   task automatic applyStimulus(input string tag, input logic [31:0] e1,
                                input logic [31:0] e2, input logic es);
      exp_t e;
      e.tag = {tag, "/rd1"};   e.port = 1; e.value = e1;           sb.push_back(e);
      e.tag = {tag, "/rd2"};   e.port = 2; e.value = e2;           sb.push_back(e);
      e.tag = {tag, "/stall"}; e.port = 3; e.value = {31'd0, es};  sb.push_back(e);
   endtask

   // Let combinational outputs settle, then drain the scoreboard.
   task automatic checkOutput();
      exp_t        e;
      logic [31:0] obs;
      #1;
      while (sb.size() > 0) begin
         e = sb.pop_front();
         case (e.port)
            1:       obs = read_data_1;
            2:       obs = read_data_2;
            default: obs = {31'd0, stall_req};
         endcase
         total++;
         assert (obs === e.value) else begin
            bad++;
            $error("[TB] FAIL %s observed=0x%08h expected=0x%08h", e.tag, obs, e.value);
         end
      end
   endtask

   initial begin
      rst = 1'b1;
      idleInputs();
      repeat (2) @(posedge clk);

      // Reset drops a WB write and gates outputs and stall even with a hazard present.
      @(negedge clk);
      rst = 1'b1;
      wb_write_en = 1'b1; wb_write_addr = 5'd5; wb_write_data = 32'hDEAD;
      read_en_1 = 1'b1; read_addr_1 = 5'd5;
      ex_write_en = 1'b1; ex_write_addr = 5'd5; ex_write_data = 32'h1; ex_is_load = 1'b1;
      read_en_2 = 1'b1; read_addr_2 = 5'd5;
      applyStimulus("rst_hold", 32'h0, 32'h0, 1'b0);
      checkOutput();
      @(negedge clk);
      rst = 1'b0;
      idleInputs();
      read_en_1 = 1'b1; read_addr_1 = 5'd5;
      applyStimulus("rst_clear_r5", 32'h0, 32'h0, 1'b0);
      checkOutput();

      // WB write-through in the same cycle, then the stored value.
      @(negedge clk);
      idleInputs();
      wb_write_en = 1'b1; wb_write_addr = 5'd8; wb_write_data = 32'h1234;
      read_en_1 = 1'b1; read_addr_1 = 5'd8;
      applyStimulus("wb_through", 32'h1234, 32'h0, 1'b0);
      checkOutput();
      @(negedge clk);
      idleInputs();
      read_en_1 = 1'b1; read_addr_1 = 5'd8;
      read_en_2 = 1'b1; read_addr_2 = 5'd8;
      applyStimulus("gpr_r8_both", 32'h1234, 32'h1234, 1'b0);
      checkOutput();

      // Forward priority: EX over MEM over WB, all within one cycle.
      @(negedge clk);
      idleInputs();
      ex_write_en  = 1'b1; ex_write_addr  = 5'd3; ex_write_data  = 32'hA;
      mem_write_en = 1'b1; mem_write_addr = 5'd3; mem_write_data = 32'hB;
      wb_write_en  = 1'b1; wb_write_addr  = 5'd3; wb_write_data  = 32'hC;
      read_en_2 = 1'b1; read_addr_2 = 5'd3;
      applyStimulus("fwd_ex", 32'h0, 32'hA, 1'b0);
      checkOutput();
      ex_write_en = 1'b0;
      applyStimulus("fwd_mem", 32'h0, 32'hB, 1'b0);
      checkOutput();
      mem_write_en = 1'b0;
      applyStimulus("fwd_wb", 32'h0, 32'hC, 1'b0);
      checkOutput();
      @(negedge clk);
      idleInputs();
      read_en_1 = 1'b1; read_addr_1 = 5'd3;
      read_en_2 = 1'b0; read_addr_2 = 5'd3;
      applyStimulus("gpr_r3_en_off", 32'hC, 32'h0, 1'b0);
      checkOutput();

      // r0 guard against WB, MEM and EX producers.
      @(negedge clk);
      idleInputs();
      wb_write_en  = 1'b1; wb_write_addr  = 5'd0; wb_write_data  = 32'hFFFFFFFF;
      mem_write_en = 1'b1; mem_write_addr = 5'd0; mem_write_data = 32'h66;
      ex_write_en  = 1'b1; ex_write_addr  = 5'd0; ex_write_data  = 32'h55;
      read_en_1 = 1'b1; read_addr_1 = 5'd0;
      read_en_2 = 1'b1; read_addr_2 = 5'd0;
      applyStimulus("r0_fwd", 32'h0, 32'h0, 1'b0);
      checkOutput();

      // Load-use: one stall cycle, then MEM supplies the loaded value.
      @(negedge clk);
      idleInputs();
      ex_write_en = 1'b1; ex_write_addr = 5'd9; ex_write_data = 32'hBAD; ex_is_load = 1'b1;
      read_en_1 = 1'b1; read_addr_1 = 5'd8;
      read_en_2 = 1'b1; read_addr_2 = 5'd9;
      applyStimulus("load_use_stall", 32'h1234, 32'hBAD, 1'b1);
      checkOutput();
      @(negedge clk);
      idleInputs();
      mem_write_en = 1'b1; mem_write_addr = 5'd9; mem_write_data = 32'h77;
      read_en_1 = 1'b1; read_addr_1 = 5'd8;
      read_en_2 = 1'b1; read_addr_2 = 5'd9;
      applyStimulus("load_use_mem", 32'h1234, 32'h77, 1'b0);
      checkOutput();

      // Load-use seen from port 1.
      @(negedge clk);
      idleInputs();
      ex_write_en = 1'b1; ex_write_addr = 5'd8; ex_write_data = 32'h4; ex_is_load = 1'b1;
      read_en_1 = 1'b1; read_addr_1 = 5'd8;
      applyStimulus("load_use_p1", 32'h4, 32'h0, 1'b1);
      checkOutput();

      // No false stall: disabled port, load to r0, non-load producer.
      @(negedge clk);
      idleInputs();
      ex_write_en = 1'b1; ex_write_addr = 5'd9; ex_write_data = 32'h9; ex_is_load = 1'b1;
      read_en_2 = 1'b0; read_addr_2 = 5'd9;
      applyStimulus("nostall_en_off", 32'h0, 32'h0, 1'b0);
      checkOutput();
      ex_write_addr = 5'd0;
      read_en_1 = 1'b1; read_addr_1 = 5'd0;
      read_en_2 = 1'b1; read_addr_2 = 5'd0;
      applyStimulus("nostall_r0", 32'h0, 32'h0, 1'b0);
      checkOutput();
      ex_write_addr = 5'd9; ex_is_load = 1'b0;
      read_addr_2 = 5'd9;
      applyStimulus("nostall_alu", 32'h0, 32'h9, 1'b0);
      checkOutput();

      // Mid-operation reset wipes stored state and drops the colliding write.
      @(negedge clk);
      idleInputs();
      wb_write_en = 1'b1; wb_write_addr = 5'd12; wb_write_data = 32'h12;
      @(negedge clk);
      idleInputs();
      read_en_1 = 1'b1; read_addr_1 = 5'd12;
      applyStimulus("pre_reset_r12", 32'h12, 32'h0, 1'b0);
      checkOutput();
      @(negedge clk);
      rst = 1'b1;
      wb_write_en = 1'b1; wb_write_addr = 5'd12; wb_write_data = 32'h99;
      @(negedge clk);
      rst = 1'b0;
      idleInputs();
      read_en_1 = 1'b1; read_addr_1 = 5'd12;
      read_en_2 = 1'b1; read_addr_2 = 5'd8;
      applyStimulus("post_reset", 32'h0, 32'h0, 1'b0);
      checkOutput();

      @(negedge clk);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
